cla_adder: RTL and testbench

- Registered 4-bit carry-lookahead adder. Computes a + b + cin with fully parallel lookahead carries, no ripple chain.
- Exposes the complete internal carry vector and group propagate/generate signals so it can be cascaded as a leaf in wider lookahead trees.
- One clock domain; all outputs registered.

---
 rtl/cla_adder.sv | 92 +++++++++
 tb/tb_cla_adder.sv | 129 ++++++++++++
 2 files changed

// File: rtl/cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : cla_adder
// Brief    : Registered carry-lookahead adder, two-level SOP carries per group,
//            groups chained through group propagate/generate.
// Revision : 1.0
// ============================================================================
module cla_adder #(
    parameter int WIDTH = 4,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH:0]   cout,
    output logic             group_p,
    output logic             group_g
);

    localparam int c_NGROUPS = WIDTH / GROUP;

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_c;
    logic             w_blk_p;
    logic             w_blk_g;

    logic [WIDTH-1:0] r_sum;
    logic [WIDTH:0]   r_cout;
    logic             r_group_p;
    logic             r_group_g;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Each carry inside a group is g_j | p_j g_{j-1} | ... | p_j..p_0 cg,
    // built from the group carry-in rather than from the previous bit.
    always_comb begin : comb_lookahead
        logic w_cg;
        logic w_prod;
        logic w_terms;
        w_c     = '0;
        w_c[0]  = cin;
        w_blk_p = 1'b1;
        w_blk_g = 1'b0;
        w_cg    = cin;
        w_prod  = 1'b1;
        w_terms = 1'b0;
        for (int k = 0; k < c_NGROUPS; k++) begin
            for (int j = 0; j < GROUP; j++) begin
                w_terms = 1'b0;
                w_prod  = 1'b1;
                for (int m = j; m >= 0; m--) begin
                    w_terms = w_terms | (w_prod & w_g[k*GROUP+m]);
                    w_prod  = w_prod & w_p[k*GROUP+m];
                end
                w_c[k*GROUP+j+1] = w_terms | (w_prod & w_cg);
            end
            // After the last bit, w_terms/w_prod are this group's G and P.
            w_cg    = w_terms | (w_prod & w_cg);
            w_blk_g = w_terms | (w_prod & w_blk_g);
            w_blk_p = w_blk_p & w_prod;
        end
    end

    assign w_sum = w_p ^ w_c[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum     <= '0;
            r_cout    <= '0;
            r_group_p <= 1'b0;
            r_group_g <= 1'b0;
        end else begin
            r_sum     <= w_sum;
            r_cout    <= w_c;
            r_group_p <= w_blk_p;
            r_group_g <= w_blk_g;
        end
    end

    assign sum     = r_sum;
    assign cout    = r_cout;
    assign group_p = r_group_p;
    assign group_g = r_group_g;

endmodule
`default_nettype wire

// File: tb/tb_cla_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_adder
// Brief    : Directed and exhaustive checks of cla_adder against hand values
//            and an arithmetic reference.
// Revision : 1.0
// ============================================================================
module tb_cla_adder;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic [4:0] cout;
    logic       group_p;
    logic       group_g;

    int n_checks;
    int n_errors;

    cla_adder #(.WIDTH(4), .GROUP(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .sum     (sum),
        .cout    (cout),
        .group_p (group_p),
        .group_g (group_g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] es, input logic [4:0] ec,
                             input logic ep, input logic eg);
        check({tag, ".sum"},  {28'd0, sum},     {28'd0, es});
        check({tag, ".cout"}, {27'd0, cout},    {27'd0, ec});
        check({tag, ".gp"},   {31'd0, group_p}, {31'd0, ep});
        check({tag, ".gg"},   {31'd0, group_g}, {31'd0, eg});
    endtask

    initial begin
        logic [4:0] ref_total;
        logic [4:0] ref_c;
        logic [4:0] part;
        logic [3:0] mask;
        n_checks = 0;
        n_errors = 0;

        rst = 1'b1; a = 4'b1111; b = 4'b1111; cin = 1'b1;
        step();
        step();
        check_all("reset", 4'b0000, 5'b00000, 1'b0, 1'b0);

        rst = 1'b0; a = 4'b0000; b = 4'b0000; cin = 1'b0;
        step();
        check_all("zero", 4'b0000, 5'b00000, 1'b0, 1'b0);

        a = 4'b0110; b = 4'b1011; cin = 1'b0;
        step();
        check_all("6p11", 4'b0001, 5'b11100, 1'b0, 1'b1);

        a = 4'b1111; b = 4'b0001; cin = 1'b0;
        step();
        check_all("15p1", 4'b0000, 5'b11110, 1'b0, 1'b1);

        a = 4'b1010; b = 4'b0101; cin = 1'b1;
        step();
        check_all("prop", 4'b0000, 5'b11111, 1'b1, 1'b0);

        // back-to-back issue, one result per edge
        a = 4'b1100; b = 4'b0011; cin = 1'b1;
        step();
        check_all("b2b0", 4'b0000, 5'b11111, 1'b1, 1'b0);
        a = 4'b0000; b = 4'b0000; cin = 1'b0;
        step();
        check_all("b2b1", 4'b0000, 5'b00000, 1'b0, 1'b0);

        // reset on the second edge discards the in-flight result
        a = 4'b1100; b = 4'b0011; cin = 1'b1;
        step();
        check_all("rb2b0", 4'b0000, 5'b11111, 1'b1, 1'b0);
        rst = 1'b1; a = 4'b0101; b = 4'b0101; cin = 1'b1;
        step();
        check_all("rb2b1", 4'b0000, 5'b00000, 1'b0, 1'b0);
        rst = 1'b0;

        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a = 4'(ia); b = 4'(ib); cin = 1'(ic);
                    step();
                    ref_total = 5'(ia + ib + ic);
                    for (int i = 0; i <= 4; i++) begin
                        mask = 4'((1 << i) - 1);
                        part = {1'b0, a & mask} + {1'b0, b & mask} + {4'd0, cin};
                        ref_c[i] = part[i];
                    end
                    check("sweep.total", {27'd0, cout[4], sum}, {27'd0, ref_total});
                    check("sweep.cout",  {27'd0, cout}, {27'd0, ref_c});
                    check("sweep.gp",    {31'd0, group_p}, {31'd0, &(a ^ b)});
                    check("sweep.gg",    {31'd0, group_g}, {31'd0, ({1'b0, a} + {1'b0, b}) >> 4});
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
